// File: rtl/gate_response_checker.sv
// Response analyser for the exhaustive 5-bit gate sweep.
// Optional MISR signature: define GATE_CHK_SIGNATURE_EN.
module gate_response_checker #(
  parameter logic [31:0] EXP_TABLE = 32'h8000_0000,
  parameter int unsigned ERR_W     = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic [4:0]       i_vec,
  input  logic             i_y,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic             o_err_seen,
  output logic [4:0]       o_first_err_vec,
  output logic [31:0]      o_cov,
  output logic [15:0]      o_signature
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic        acc;
  logic        mism;
  logic [31:0] vec_bit;
  logic [31:0] cov_d;

  // A sample counts only in RUN and only when no start collides with it
  always_comb begin
    acc     = (state_q == RUN) && i_valid && !i_start;
    mism    = acc && (i_y != EXP_TABLE[i_vec]);
    vec_bit = '0;
    vec_bit[i_vec] = acc;
    cov_d   = o_cov | vec_bit;
  end

  // Next state looks at the updated coverage so done lands on the same edge
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (i_start) state_d = RUN;
      RUN: begin
        if (i_start)      state_d = RUN;
        else if (&cov_d)  state_d = DONE;
      end
      DONE: if (i_start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Result registers: cleared by start, updated by accepted samples
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_cnt       <= '0;
      o_err_seen      <= 1'b0;
      o_first_err_vec <= '0;
      o_cov           <= '0;
    end else if (i_start) begin
      o_err_cnt       <= '0;
      o_err_seen      <= 1'b0;
      o_first_err_vec <= '0;
      o_cov           <= '0;
    end else if (acc) begin
      o_cov <= cov_d;
      if (mism) begin
        if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + 1'b1;
        o_err_seen <= 1'b1;
        if (!o_err_seen) o_first_err_vec <= i_vec;
      end
    end
  end

`ifdef GATE_CHK_SIGNATURE_EN
  logic [15:0] sig_q;
  logic        fb;

  assign fb = sig_q[15] ^ i_y;

  // CRC-16-CCITT MISR over the accepted response stream
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     sig_q <= 16'h0000;
    else if (i_start) sig_q <= 16'hFFFF;
    else if (acc)     sig_q <= {sig_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  end

  assign o_signature = sig_q;
`else
  assign o_signature = 16'h0000;
`endif

  assign o_busy = (state_q == RUN);
  assign o_done = (state_q == DONE);
  assign o_pass = o_done && (o_err_cnt == '0);

endmodule
